lpc_bus_sched: RTL and testbench

Sequencer and arbiter for the LPC host master. Two requesters share the single LPC memory-cycle master: a read-only instruction-fetch port and a read/write data port. The block sits between the core's memory ports and the master's `go`/`done` handshake. It splits 16- and 32-bit accesses into sequential single-byte LPC cycles, assembles little-endian results, and returns a one-cycle `ack` to the granted requester.

---
 rtl/lpc_bus_sched.sv | 148 ++++++++++++++
 tb/tb_lpc_bus_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_bus_sched.sv
// Arbitrates the fetch and data ports onto one LPC byte master, splitting
// wider accesses into sequential byte cycles and assembling little-endian reads.
module lpc_bus_sched (
    input  logic        lclk,
    input  logic        lreset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_dir,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        m_go,
    output logic        m_dir,
    output logic [31:0] m_addr,
    output logic [7:0]  m_wdata,
    input  logic [7:0]  m_rdata,
    input  logic        m_done
);
    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, RESP} state_t;

    state_t      state, state_n;
    logic        rr_data, rr_data_n;   // 1: data port wins the next tie
    logic        owner, owner_n;       // 1: data port owns the transaction
    logic [31:0] base, base_n;
    logic        dir, dir_n;
    logic [31:0] wdata, wdata_n;
    logic [1:0]  last, last_n;
    logic [1:0]  idx, idx_n;
    logic        m_go_n, m_dir_n, if_ack_n, d_ack_n;
    logic [31:0] m_addr_n, rdata_n;
    logic [7:0]  m_wdata_n;
    logic        grant_d, load;

    always_comb begin
        state_n   = state;
        rr_data_n = rr_data;
        owner_n   = owner;
        base_n    = base;
        dir_n     = dir;
        wdata_n   = wdata;
        last_n    = last;
        idx_n     = idx;
        m_go_n    = m_go;
        m_dir_n   = m_dir;
        m_addr_n  = m_addr;
        m_wdata_n = m_wdata;
        rdata_n   = rdata;
        if_ack_n  = 1'b0;
        d_ack_n   = 1'b0;
        grant_d   = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (!m_done && (if_req || d_req)) begin
                    grant_d = d_req && (!if_req || rr_data);
                    if (if_req && d_req)
                        rr_data_n = !grant_d;
                    owner_n = grant_d;
                    base_n  = grant_d ? d_addr : if_addr;
                    dir_n   = grant_d && d_dir;
                    wdata_n = grant_d ? d_wdata : 32'h0;
                    if (grant_d && d_size == 2'd0)
                        last_n = 2'd0;
                    else if (grant_d && d_size == 2'd1)
                        last_n = 2'd1;
                    else
                        last_n = 2'd3;
                    idx_n   = 2'd0;
                    rdata_n = 32'h0;
                    load    = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (m_done) begin
                    if (!dir)
                        rdata_n[{idx, 3'b000} +: 8] = m_rdata;
                    m_go_n  = 1'b0;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (!m_done) begin
                    if (idx == last) begin
                        if_ack_n = !owner;
                        d_ack_n  = owner;
                        state_n  = RESP;
                    end else begin
                        idx_n   = idx + 2'd1;
                        load    = 1'b1;
                        state_n = ISSUE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // Every byte cycle is launched from the latched context plus the byte index.
        if (load) begin
            m_go_n    = 1'b1;
            m_dir_n   = dir_n;
            m_addr_n  = base_n + {30'h0, idx_n};
            m_wdata_n = wdata_n[{idx_n, 3'b000} +: 8];
        end
    end

    always_ff @(posedge lclk) begin
        if (lreset) begin
            state   <= IDLE;
            rr_data <= 1'b1;
            owner   <= 1'b0;
            base    <= 32'h0;
            dir     <= 1'b0;
            wdata   <= 32'h0;
            last    <= 2'd0;
            idx     <= 2'd0;
            m_go    <= 1'b0;
            m_dir   <= 1'b0;
            m_addr  <= 32'h0;
            m_wdata <= 8'h0;
            rdata   <= 32'h0;
            if_ack  <= 1'b0;
            d_ack   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            rr_data <= rr_data_n;
            owner   <= owner_n;
            base    <= base_n;
            dir     <= dir_n;
            wdata   <= wdata_n;
            last    <= last_n;
            idx     <= idx_n;
            m_go    <= m_go_n;
            m_dir   <= m_dir_n;
            m_addr  <= m_addr_n;
            m_wdata <= m_wdata_n;
            rdata   <= rdata_n;
            if_ack  <= if_ack_n;
            d_ack   <= d_ack_n;
            busy    <= (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_lpc_bus_sched.sv
// Directed bench for lpc_bus_sched with a behavioural LPC byte master.
module tb_lpc_bus_sched;
    logic        lclk = 1'b0;
    logic        lreset = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_dir = 1'b0;
    logic [1:0]  d_size = 2'd0;
    logic [31:0] if_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0;
    logic        if_ack, d_ack, busy, m_go, m_dir, m_done;
    logic [31:0] rdata, m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  m_rdata = 8'h0;

    int vectors = 0;
    int miscompares = 0;

    lpc_bus_sched dut (
        .lclk(lclk), .lreset(lreset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .d_req(d_req), .d_dir(d_dir), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .rdata(rdata), .busy(busy),
        .m_go(m_go), .m_dir(m_dir), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_done(m_done)
    );

    always #5 lclk = ~lclk;

    // Master model: done rises delay_cfg cycles after go is seen, clears once go drops.
    logic       done_q = 1'b0;
    logic       force_done = 1'b0;
    int         delay_cfg = 0;
    int         dcnt = 0;
    logic [7:0] rd_tab [4];
    assign m_done = done_q | force_done;

    always @(posedge lclk) begin
        if (!m_go) begin
            done_q <= 1'b0;
            dcnt   <= 0;
        end else if (!done_q) begin
            if (dcnt >= delay_cfg) begin
                done_q  <= 1'b1;
                m_rdata <= rd_tab[m_addr[1:0]];
            end else begin
                dcnt <= dcnt + 1;
            end
        end
    end

    // Bus monitor: logs each byte cycle launch, ack order and go protocol violations.
    logic [31:0] log_addr[$];
    logic [7:0]  log_wd[$];
    logic        log_dir[$];
    byte         ack_order[$];
    logic        prev_go = 1'b0, prev_done = 1'b0;
    int          rise_bad = 0, drop_bad = 0, go_hi = 0, dack_cnt = 0, iack_cnt = 0;

    always @(posedge lclk) begin
        prev_go   <= m_go;
        prev_done <= m_done;
        if (m_go) go_hi <= go_hi + 1;
        if (m_go && !prev_go) begin
            log_addr.push_back(m_addr);
            log_wd.push_back(m_wdata);
            log_dir.push_back(m_dir);
            if (m_done) rise_bad <= rise_bad + 1;
        end
        if (prev_go && !m_go && !prev_done && !lreset) drop_bad <= drop_bad + 1;
        if (d_ack) begin dack_cnt <= dack_cnt + 1; ack_order.push_back("D"); end
        if (if_ack) begin iack_cnt <= iack_cnt + 1; ack_order.push_back("I"); end
    end

    task automatic clear_logs();
        log_addr.delete(); log_wd.delete(); log_dir.delete(); ack_order.delete();
    endtask

    // Waits at falling edges until either ack is seen; got=0 when the budget expires.
    task automatic wait_ack(input int lim, output bit got);
        got = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge lclk);
            if (if_ack || d_ack) begin got = 1; break; end
        end
    endtask

    task automatic test_reset();
        lreset = 1'b1;
        repeat (3) @(negedge lclk);
        vectors++;
        if ({m_go, m_dir, if_ack, d_ack, busy} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 00000", {m_go, m_dir, if_ack, d_ack, busy});
        end
        vectors++;
        if ({m_addr, m_wdata, rdata} !== 72'h0) begin
            miscompares++;
            $display("FAIL reset_data got addr=%h wd=%h rd=%h want 0", m_addr, m_wdata, rdata);
        end
        lreset = 1'b0;
        @(negedge lclk);
    endtask

    task automatic test_fetch();
        bit got;
        clear_logs();
        rd_tab = '{8'h11, 8'h22, 8'h33, 8'h44};
        if_addr = 32'h0000_1000;
        if_req = 1'b1;
        wait_ack(200, got);
        if_req = 1'b0;
        vectors++;
        if (!(got && if_ack)) begin
            miscompares++;
            $display("FAIL fetch_ack got %b want if_ack", got);
        end
        vectors++;
        if (rdata !== 32'h4433_2211) begin
            miscompares++;
            $display("FAIL fetch_rdata got %h want 44332211", rdata);
        end
        vectors++;
        if (log_addr.size() != 4 || log_addr[0] !== 32'h1000 || log_addr[3] !== 32'h1003 ||
            log_dir[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_cycles got n=%0d first=%h want 4 cycles 1000..1003 reads",
                     log_addr.size(), (log_addr.size() > 0) ? log_addr[0] : 32'hx);
        end
        repeat (10) @(negedge lclk);
        vectors++;
        if (ack_order.size() != 1) begin
            miscompares++;
            $display("FAIL fetch_ack_once got %0d acks want 1", ack_order.size());
        end
    endtask

    task automatic test_write_half();
        bit got;
        clear_logs();
        d_dir = 1'b1; d_size = 2'd1; d_addr = 32'hFFFF_FFFF; d_wdata = 32'hAABB_CCDD;
        d_req = 1'b1;
        wait_ack(200, got);
        d_req = 1'b0;
        vectors++;
        if (!(got && d_ack)) begin
            miscompares++;
            $display("FAIL whalf_ack got %b want d_ack", got);
        end
        vectors++;
        if (rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL whalf_rdata got %h want 0", rdata);
        end
        vectors++;
        if (log_addr.size() != 2 || log_addr[0] !== 32'hFFFF_FFFF || log_wd[0] !== 8'hDD ||
            log_addr[1] !== 32'h0 || log_wd[1] !== 8'hCC || log_dir[0] !== 1'b1 || log_dir[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL whalf_cycles got n=%0d want FFFFFFFF/DD then 00000000/CC writes", log_addr.size());
        end
        repeat (5) @(negedge lclk);
    endtask

    task automatic test_byte_delay();
        bit got;
        int hi0;
        clear_logs();
        delay_cfg = 5;
        rd_tab = '{8'h5A, 8'h00, 8'h00, 8'h00};
        d_dir = 1'b0; d_size = 2'd0; d_addr = 32'h20;
        hi0 = go_hi;
        d_req = 1'b1;
        wait_ack(200, got);
        d_req = 1'b0;
        vectors++;
        if (!(got && d_ack) || rdata !== 32'h0000_005A) begin
            miscompares++;
            $display("FAIL byte_read got ack=%b rdata=%h want 1 0000005a", got, rdata);
        end
        vectors++;
        if (drop_bad != 0 || go_hi - hi0 < 6) begin
            miscompares++;
            $display("FAIL go_hold got drops=%0d hi=%0d want 0 drops hi>=6", drop_bad, go_hi - hi0);
        end
        delay_cfg = 0;
        repeat (5) @(negedge lclk);
    endtask

    task automatic test_back_to_back();
        bit got;
        lreset = 1'b1;
        d_dir = 1'b0; d_size = 2'd0; d_addr = 32'h40; if_addr = 32'h80;
        if_req = 1'b1; d_req = 1'b1;
        repeat (2) @(negedge lclk);
        clear_logs();
        lreset = 1'b0;
        for (int k = 0; k < 4; k++) wait_ack(200, got);
        if_req = 1'b0; d_req = 1'b0;
        repeat (3) @(negedge lclk);
        vectors++;
        if (ack_order.size() != 4 || ack_order[0] != "D" || ack_order[1] != "I" ||
            ack_order[2] != "D" || ack_order[3] != "I") begin
            miscompares++;
            $display("FAIL rr_order got %0d acks want D,I,D,I", ack_order.size());
        end
        vectors++;
        if (log_addr.size() != 10) begin
            miscompares++;
            $display("FAIL rr_cycles got %0d byte cycles want 10", log_addr.size());
        end
        vectors++;
        if (rise_bad != 0) begin
            miscompares++;
            $display("FAIL go_vs_done got %0d go rises with done high want 0", rise_bad);
        end
    endtask

    task automatic test_stale_done();
        bit got;
        int d0;
        clear_logs();
        force_done = 1'b1;
        d_dir = 1'b0; d_size = 2'd0; d_addr = 32'h20;
        d_req = 1'b1;
        repeat (10) @(negedge lclk);
        vectors++;
        if (busy !== 1'b0 || log_addr.size() != 0) begin
            miscompares++;
            $display("FAIL stale_done got busy=%b cycles=%0d want 0 0", busy, log_addr.size());
        end
        force_done = 1'b0;
        wait_ack(200, got);
        d_req = 1'b0;
        vectors++;
        if (!(got && d_ack)) begin
            miscompares++;
            $display("FAIL stale_release got %b want d_ack", got);
        end
        repeat (3) @(negedge lclk);
        // Word read interrupted by reset during its second byte.
        clear_logs();
        d_size = 2'd2;
        d_req = 1'b1;
        for (int i = 0; i < 200 && log_addr.size() < 2; i++) @(negedge lclk);
        d_req = 1'b0;
        lreset = 1'b1;
        d0 = dack_cnt;
        @(negedge lclk);
        vectors++;
        if ({m_go, m_dir, if_ack, d_ack, busy} !== 5'b0 || {m_addr, m_wdata, rdata} !== 72'h0) begin
            miscompares++;
            $display("FAIL mid_reset got go=%b busy=%b addr=%h rd=%h want all 0", m_go, busy, m_addr, rdata);
        end
        @(negedge lclk);
        lreset = 1'b0;
        repeat (20) @(negedge lclk);
        vectors++;
        if (dack_cnt != d0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_noack got acks=%0d busy=%b want 0 0", dack_cnt - d0, busy);
        end
    endtask

    task automatic test_req_drop();
        bit got;
        int d0;
        d0 = dack_cnt;
        d_dir = 1'b0; d_size = 2'd0; d_addr = 32'h20;
        d_req = 1'b1;
        for (int i = 0; i < 50 && !busy; i++) @(negedge lclk);
        d_req = 1'b0;
        wait_ack(200, got);
        vectors++;
        if (!(got && d_ack)) begin
            miscompares++;
            $display("FAIL req_drop got %b want d_ack", got);
        end
        repeat (10) @(negedge lclk);
        vectors++;
        if (dack_cnt - d0 != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL req_drop_once got %0d acks busy=%b want 1 0", dack_cnt - d0, busy);
        end
    endtask

    initial begin
        rd_tab = '{8'h0, 8'h0, 8'h0, 8'h0};
        test_reset();
        test_fetch();
        test_write_half();
        test_byte_delay();
        test_back_to_back();
        test_stale_done();
        test_req_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
